// File: rtl/instruction_queue_if.sv
// Decoder/sequencer side of the decoded-instruction queue: push, pop, flush
// and the status the sequencer uses to gate dispatch.
interface instruction_queue_if #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  full;
  logic                  nearly_full;
  logic                  resetting;
  logic [CW-1:0]         count;
  logic                  overflow;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, empty, full, nearly_full, resetting, count, overflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, empty, full, nearly_full, resetting, count, overflow
  );
endinterface

// File: rtl/instruction_queue.sv
// First-word-fall-through circular queue of decoded instructions between the
// decoder and the microcode sequencer, with flush/redirect handling.
module instruction_queue #(
  parameter int DATA_WIDTH        = 64,
  parameter int DEPTH             = 4,
  parameter int NEARLY_FULL_LEVEL = 3
) (
  input  logic             clk,
  input  logic             reset,
  instruction_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_NF    = CW'(NEARLY_FULL_LEVEL);
  localparam logic [CW-1:0] C_ZERO  = {CW{1'b0}};

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_FLUSHING = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  w_resetting;
  logic                  w_ops_ok;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_drop;

  // Flush state register: FLUSHING covers every cycle after a flush edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Flush state next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (q.flush) w_state_next = ST_FLUSHING;
        else         w_state_next = ST_RUN;
      end
      ST_FLUSHING: begin
        if (q.flush) w_state_next = ST_FLUSHING;
        else         w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign w_resetting = (r_state == ST_FLUSHING);
  assign w_ops_ok    = ~q.flush & ~w_resetting;
  // A pop frees a slot in the same cycle, so a full queue still takes a write.
  assign w_rd_acc    = q.rd_en & w_ops_ok & (r_count != C_ZERO);
  assign w_wr_acc    = q.wr_en & w_ops_ok & ((r_count != C_DEPTH) | w_rd_acc);
  assign w_drop      = q.wr_en & w_ops_ok & ~w_wr_acc;

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_count    <= C_ZERO;
      r_overflow <= 1'b0;
    end else if (q.flush) begin
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_count    <= C_ZERO;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + CW'(1);
      else if (w_rd_acc && !w_wr_acc) r_count <= r_count - CW'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Entry storage, cleared on reset so the head reads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {DATA_WIDTH{1'b0}};
    end else if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= q.wr_data;
    end
  end

  assign q.rd_data     = r_mem[r_rd_ptr];
  assign q.count       = r_count;
  assign q.empty       = (r_count == C_ZERO) | w_resetting;
  assign q.full        = (r_count == C_DEPTH);
  assign q.nearly_full = (r_count >= C_NF);
  assign q.resetting   = w_resetting;
  assign q.overflow    = r_overflow;
endmodule
